// File: rtl/alu_exec_stage.sv
// alu_exec_stage: MIPS execute-stage ALU feeding a one-entry registered
// output slot, with valid/ready handshakes on both sides and flush.
module alu_exec_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_op,
    input  logic [DATA_W-1:0] in_src_a,
    input  logic [DATA_W-1:0] in_src_b,
    input  logic [4:0]        in_dest,
    input  logic              in_wen,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_dest,
    output logic              out_wen,
    output logic              out_ovf
);

    typedef enum logic [3:0] {
        OP_ADDU = 4'b0000,
        OP_SUBU = 4'b0001,
        OP_CLZ  = 4'b0010,
        OP_CLO  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_SLTU = 4'b0111,
        OP_NOR  = 4'b1000,
        OP_XOR  = 4'b1001,
        OP_SEB  = 4'b1010,
        OP_SEH  = 4'b1011,
        OP_ADD  = 4'b1110,
        OP_SUB  = 4'b1111
    } alu_op_e;

    localparam int MSB = DATA_W - 1;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, res_d;
    logic [4:0]        dest_q;
    logic              wen_q;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] sum, diff;
    logic [5:0]        lz_a, lo_a;
    logic              xfer_in, load;

    function automatic logic [5:0] lead_zeros(input logic [DATA_W-1:0] v);
        logic [5:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (v[i]) hit = 1'b1;
            else if (!hit) n = n + 6'd1;
        end
        return n;
    endfunction

    assign sum  = in_src_a + in_src_b;
    assign diff = in_src_a - in_src_b;
    assign lz_a = lead_zeros(in_src_a);
    assign lo_a = lead_zeros(~in_src_a);

    always_comb begin
        res_d = sum;
        ovf_d = 1'b0;
        case (alu_op_e'(in_alu_op))
            OP_SUBU: res_d = diff;
            OP_CLZ:  res_d = {{(DATA_W-6){1'b0}}, lz_a};
            OP_CLO:  res_d = {{(DATA_W-6){1'b0}}, lo_a};
            OP_AND:  res_d = in_src_a & in_src_b;
            OP_SLT:  res_d = {{(DATA_W-1){1'b0}},
                              $signed(in_src_a) < $signed(in_src_b)};
            OP_OR:   res_d = in_src_a | in_src_b;
            OP_SLTU: res_d = {{(DATA_W-1){1'b0}}, in_src_a < in_src_b};
            OP_NOR:  res_d = ~(in_src_a | in_src_b);
            OP_XOR:  res_d = in_src_a ^ in_src_b;
            OP_SEB:  res_d = {{(DATA_W-8){in_src_b[7]}}, in_src_b[7:0]};
            OP_SEH:  res_d = {{(DATA_W-16){in_src_b[15]}}, in_src_b[15:0]};
            OP_ADD: begin
                res_d = sum;
                ovf_d = (in_src_a[MSB] == in_src_b[MSB]) &&
                        (sum[MSB] != in_src_a[MSB]);
            end
            OP_SUB: begin
                res_d = diff;
                ovf_d = (in_src_a[MSB] != in_src_b[MSB]) &&
                        (diff[MSB] != in_src_a[MSB]);
            end
            default: res_d = sum;
        endcase
    end

    assign in_ready = !valid_q || out_ready;
    assign xfer_in  = in_valid && in_ready;
    assign load     = xfer_in && !flush;

    // Flush beats everything; a drain without a refill empties the slot.
    always_comb begin
        valid_d = valid_q;
        if (flush)        valid_d = 1'b0;
        else if (xfer_in) valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            dest_q   <= '0;
            wen_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                result_q <= res_d;
                dest_q   <= in_dest;
                wen_q    <= in_wen && !ovf_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_dest   = dest_q;
    assign out_wen    = wen_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: scoreboard bench for the execute-stage ALU;
// expectations come from an independent reference model.
module tb_alu_exec_stage;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  dest;
        logic        wen;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_alu_op = '0;
    logic [31:0] in_src_a = '0;
    logic [31:0] in_src_b = '0;
    logic [4:0]  in_dest = '0;
    logic        in_wen = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        out_ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_exec_stage dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu_op  (in_alu_op),
        .in_src_a   (in_src_a),
        .in_src_b   (in_src_b),
        .in_dest    (in_dest),
        .in_wen     (in_wen),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest),
        .out_wen    (out_wen),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "timeout");
    end

    function automatic int count_lead(input logic [31:0] v);
        int n = 0;
        while (n < 32 && v[31-n] == 1'b0) n++;
        return n;
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] d,
                                   input logic w);
        exp_t   e;
        longint s;
        e.dest = d;
        e.ovf  = 1'b0;
        case (op)
            4'd1:  e.result = a - b;
            4'd2:  e.result = 32'(count_lead(a));
            4'd3:  e.result = 32'(count_lead(~a));
            4'd4:  e.result = a & b;
            4'd5:  e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  e.result = a | b;
            4'd7:  e.result = (a < b) ? 32'd1 : 32'd0;
            4'd8:  e.result = ~(a | b);
            4'd9:  e.result = a ^ b;
            4'd10: e.result = 32'($signed(b[7:0]));
            4'd11: e.result = 32'($signed(b[15:0]));
            4'd14: begin
                e.result = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd15: begin
                e.result = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: e.result = a + b;
        endcase
        e.wen = w & ~e.ovf;
        return e;
    endfunction

    task automatic send(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d,
                        input logic w, input bit push);
        in_valid  = 1'b1;
        in_alu_op = op;
        in_src_a  = a;
        in_src_b  = b;
        in_dest   = d;
        in_wen    = w;
        if (push) sb.push_back(model(op, a, b, d, w));
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_dest !== 5'd0 ||
            out_wen !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: v=%b r=%h d=%0d w=%b o=%b required all 0",
                     out_valid, out_result, out_dest, out_wen, out_ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Back-to-back stream; each result is checked the cycle after issue.
    task automatic run_table(input string name, input logic [3:0] ops[],
                             input logic [31:0] as[], input logic [31:0] bs[]);
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < ops.size(); i++) begin
            send(ops[i], as[i], bs[i], 5'(i + 3), 1'b1, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_result !== e.result ||
                out_dest !== e.dest || out_wen !== e.wen || out_ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%b r=%h d=%0d w=%b o=%b required v=1 r=%h d=%0d w=%b o=%b",
                         name, i, out_valid, out_result, out_dest, out_wen, out_ovf,
                         e.result, e.dest, e.wen, e.ovf);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: out_valid=%b required 0", name, out_valid);
        end
    endtask

    task automatic test_overflow;
        logic [3:0]  ops[] = '{4'hE, 4'h0, 4'hF, 4'hE, 4'hF, 4'h1, 4'hC, 4'hD};
        logic [31:0] as[]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                               32'h8000_0000, 32'h0000_0005, 32'h8000_0000,
                               32'h0000_0010, 32'hFFFF_FFFF};
        logic [31:0] bs[]  = '{32'h1, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h7,
                               32'h1, 32'h0000_0020, 32'h2};
        run_table("overflow", ops, as, bs);
        checks++;
        if (model(4'hE, 32'h7FFF_FFFF, 32'h1, 5'd1, 1'b1).result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL model_add_wrap: reference model disagrees with 32'h80000000");
        end
    endtask

    task automatic test_count_ops;
        logic [3:0]  ops[] = '{4'h2, 4'h2, 4'h3, 4'h3, 4'h2, 4'h3};
        logic [31:0] as[]  = '{32'h0001_0000, 32'h0, 32'hFFFF_FFFF,
                               32'hF000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] bs[]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_table("count", ops, as, bs);
    endtask

    task automatic test_compare_ext;
        logic [3:0]  ops[] = '{4'h5, 4'h7, 4'hA, 4'hB, 4'h8, 4'h4, 4'h6, 4'h9};
        logic [31:0] as[]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                               32'h0, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234};
        logic [31:0] bs[]  = '{32'h1, 32'h1, 32'h0000_0080, 32'h1234_7FFF,
                               32'h0, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00};
        run_table("cmp_ext", ops, as, bs);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        out_ready = 1'b1;
        send(4'h0, 32'd100, 32'd23, 5'd7, 1'b1, 1'b1);
        @(negedge clk);
        send(4'h1, 32'd50, 32'd8, 5'd9, 1'b1, 1'b1);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_result !== sb[0].result || out_dest !== sb[0].dest) begin
                errors++;
                $display("FAIL stall[%0d]: in_ready=%b v=%b r=%h d=%0d required 0 1 %h %0d",
                         c, in_ready, out_valid, out_result, out_dest,
                         sb[0].result, sb[0].dest);
            end
        end
        out_ready = 1'b1;
        void'(sb.pop_front());
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== e.result || out_dest !== e.dest) begin
            errors++;
            $display("FAIL after_stall: v=%b r=%h d=%0d required 1 %h %0d",
                     out_valid, out_result, out_dest, e.result, e.dest);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: v=%b pending=%0d required 0 0",
                     out_valid, sb.size());
        end
    endtask

    task automatic test_flush;
        exp_t e;
        out_ready = 1'b0;
        send(4'h6, 32'h1, 32'h2, 5'd11, 1'b1, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== e.result) begin
            errors++;
            $display("FAIL pre_flush: v=%b r=%h required 1 %h",
                     out_valid, out_result, e.result);
        end
        flush = 1'b1;
        send(4'h0, 32'hDEAD, 32'h1, 5'd12, 1'b1, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: out_valid=%b required 0", out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_ghost: out_valid=%b r=%h required 0", out_valid, out_result);
        end
        send(4'h9, 32'hAAAA_5555, 32'hFFFF_0000, 5'd13, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== e.result || out_dest !== e.dest) begin
            errors++;
            $display("FAIL post_flush: v=%b r=%h d=%0d required 1 %h %0d",
                     out_valid, out_result, out_dest, e.result, e.dest);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        out_ready = 1'b0;
        send(4'hE, 32'h7FFF_FFFF, 32'h1, 5'd20, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_dest !== 5'd0 ||
            out_wen !== 1'b0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: v=%b r=%h d=%0d w=%b o=%b rdy=%b required 0 0 0 0 0 1",
                     out_valid, out_result, out_dest, out_wen, out_ovf, in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        out_ready = 1'b1;
        send(4'h1, 32'd10, 32'd3, 5'd21, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== e.result ||
            out_dest !== e.dest || out_wen !== e.wen) begin
            errors++;
            $display("FAIL post_reset: v=%b r=%h d=%0d w=%b required 1 %h %0d %b",
                     out_valid, out_result, out_dest, out_wen, e.result, e.dest, e.wen);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_count_ops();
        test_compare_ext();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
